// File: rtl/ifu_next_pc_if.sv
// Fetch-stage next-PC bundle: D-stage control fields in, fetch address and status out.
// Branch statistics outputs exist only when IFU_BRANCH_STATS_EN is defined.
interface ifu_next_pc_if;
   logic        stall;
   logic        fetch_ready;
   logic [31:0] d_pc;
   logic        br_en;
   logic        judge;
   logic [15:0] imm16;
   logic        j_en;
   logic [25:0] instr_index;
   logic        jr_en;
   logic [31:0] jr_target;
   logic [31:0] pc;
   logic [31:0] pc_plus8;
   logic        redirect;
   logic        pending;
`ifdef IFU_BRANCH_STATS_EN
   logic [31:0] br_count;
   logic [31:0] br_taken_count;

   modport master (
      output stall, fetch_ready, d_pc, br_en, judge, imm16, j_en, instr_index, jr_en, jr_target,
      input  pc, pc_plus8, redirect, pending, br_count, br_taken_count
   );
   modport slave (
      input  stall, fetch_ready, d_pc, br_en, judge, imm16, j_en, instr_index, jr_en, jr_target,
      output pc, pc_plus8, redirect, pending, br_count, br_taken_count
   );
`else
   modport master (
      output stall, fetch_ready, d_pc, br_en, judge, imm16, j_en, instr_index, jr_en, jr_target,
      input  pc, pc_plus8, redirect, pending
   );
   modport slave (
      input  stall, fetch_ready, d_pc, br_en, judge, imm16, j_en, instr_index, jr_en, jr_target,
      output pc, pc_plus8, redirect, pending
   );
`endif
endinterface

// File: rtl/ifu_next_pc.sv
// Fetch PC register / next-PC generator with one-slot branch delay and pending-redirect hold.
// Optional macro IFU_BRANCH_STATS_EN adds branch and taken-branch counters.
module ifu_next_pc #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int unsigned PC_W     = 32
) (
   input  logic          clk,
   input  logic          reset,
   ifu_next_pc_if.slave  bus
);

   typedef enum logic {RUN, HOLD_REDIR} state_t;

   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_pend_tgt;
   logic            r_pending;

   logic [PC_W-1:0] w_seq_d;
   logic [PC_W-1:0] w_br_tgt;
   logic [PC_W-1:0] w_j_tgt;
   logic [PC_W-1:0] w_target;
   logic            w_taken;
   logic            w_redirect;

   assign w_seq_d  = bus.d_pc + PC_W'(4);
   assign w_br_tgt = w_seq_d + {{(PC_W-18){bus.imm16[15]}}, bus.imm16, 2'b00};
   assign w_j_tgt  = {w_seq_d[PC_W-1 -: 4], bus.instr_index, 2'b00};
   assign w_taken  = bus.jr_en | bus.j_en | (bus.br_en & bus.judge);
   assign w_redirect = ~bus.stall & w_taken;

   always_comb begin
      w_target = w_br_tgt;
      if (bus.jr_en)     w_target = bus.jr_target;
      else if (bus.j_en) w_target = w_j_tgt;
   end

   // The delay slot sits at r_pc; a redirect only lands once that slot has been accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= RUN;
         r_pc       <= RESET_PC;
         r_pend_tgt <= '0;
         r_pending  <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               if (!bus.stall) begin
                  if (bus.fetch_ready) begin
                     r_pc <= w_redirect ? w_target : r_pc + PC_W'(4);
                  end else if (w_taken) begin
                     r_pend_tgt <= w_target;
                     r_state    <= HOLD_REDIR;
                     r_pending  <= 1'b1;
                  end
               end
            end
            HOLD_REDIR: begin
               if (!bus.stall && bus.fetch_ready) begin
                  r_pc      <= r_pend_tgt;
                  r_state   <= RUN;
                  r_pending <= 1'b0;
               end
            end
            default: begin
               r_state   <= RUN;
               r_pending <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc       = r_pc;
   assign bus.pc_plus8 = bus.d_pc + PC_W'(8);
   assign bus.redirect = w_redirect;
   assign bus.pending  = r_pending;

`ifdef IFU_BRANCH_STATS_EN
   logic [31:0] r_br_count;
   logic [31:0] r_br_taken_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_br_count       <= '0;
         r_br_taken_count <= '0;
      end else if (!bus.stall && bus.br_en) begin
         r_br_count <= r_br_count + 32'd1;
         if (bus.judge) r_br_taken_count <= r_br_taken_count + 32'd1;
      end
   end

   assign bus.br_count       = r_br_count;
   assign bus.br_taken_count = r_br_taken_count;
`endif

endmodule

// File: doc/ifu_next_pc.md
Name: ifu_next_pc

Overview:
- Fetch-stage PC register and next-PC generator; sits directly downstream of the D-stage branch comparator.
- Consumes the comparator's `judge` bit and the D-stage control/immediate fields, and drives the instruction-memory address.
- Implements the one-slot branch delay (delay slot always executes), pipeline stall hold, and a pending-redirect buffer for instruction fetch that is not ready in the cycle a redirect resolves.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- PC_W, 32, PC/address width (fixed 32; parameter for documentation only).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hazard-unit stall of F/D; PC holds, D-stage redirect inputs ignored.
- fetch_ready  input  1  instruction memory accepted the current PC this cycle.
- d_pc  input  32  PC of the instruction in D.
- br_en  input  1  D instruction is a conditional branch.
- judge  input  1  comparator result for the D branch (1 = taken).
- imm16  input  16  branch offset field of the D instruction.
- j_en  input  1  D instruction is j/jal.
- instr_index  input  26  j/jal index field.
- jr_en  input  1  D instruction is jr/jalr.
- jr_target  input  32  forwarded rs value for jr/jalr.
- pc  output  32  current fetch address (registered).
- pc_plus8  output  32  d_pc + 8, link address for jal/jalr.
- redirect  output  1  combinational; a taken control transfer is resolved this cycle (not stalled).
- pending  output  1  registered; FSM is in HOLD_REDIR.

Behaviour:
- Reset (reset low, async):
  - pc = RESET_PC.
  - FSM = RUN.
  - pending_target = 0; pending = 0.
- Target arithmetic, all mod 2^32:
  - br_tgt = d_pc + 4 + (sign_ext(imm16) << 2).
  - j_tgt = {(d_pc+4)[31:28], instr_index, 2'b00}.
  - jr target = jr_target, used unmodified.
- Selection priority:
  - jr_en > j_en > (br_en & judge).
  - Multiple enables asserted is illegal but resolved by this priority.
  - redirect = ~stall & (jr_en | j_en | (br_en & judge)).
- Sequential PC is pc + 4; wraps from 32'hFFFF_FFFC to 0.
- FSM RUN:
  - stall=1: pc holds; redirect inputs ignored; stay RUN.
  - stall=0, fetch_ready=1, redirect=1: pc <= selected target (delay slot, already fetched at pc, is skipped over by the next fetch).
  - stall=0, fetch_ready=1, redirect=0: pc <= pc + 4.
  - stall=0, fetch_ready=0, redirect=1: pc holds (delay slot still being fetched); pending_target <= selected target; go to HOLD_REDIR.
  - stall=0, fetch_ready=0, redirect=0: pc holds.
- FSM HOLD_REDIR:
  - D redirect inputs are ignored; the branch has already left D.
  - fetch_ready=1 and stall=0: pc <= pending_target; go to RUN.
  - Otherwise hold pc and pending_target.
- stall takes precedence over fetch_ready in both states.
- pc_plus8 is purely combinational from d_pc.
- Reset asserted mid-HOLD_REDIR discards the pending target.
- Misaligned jr_target is not trapped; it propagates to pc unchanged.

Optional Feature:
- Macro: IFU_BRANCH_STATS_EN.
- When defined, two extra outputs are present:
  - br_count [31:0]: increments each cycle ~stall & br_en.
  - br_taken_count [31:0]: increments each cycle ~stall & br_en & judge.
  - Both reset to 0 and wrap at 2^32.
- When undefined, neither the ports nor the logic exist; all other behaviour is identical.

Test Plan:
- Reset: reset low, then release with fetch_ready=1 and no control inputs -> pc 0x3000 on release, then 0x3004, 0x3008 on successive edges.
- Taken branch: d_pc=0x3000, br_en=1, judge=1, imm16=16'h0003, pc=0x3004, fetch_ready=1 -> redirect=1, next pc=0x3010; same with judge=0 -> pc=0x3008.
- Backward branch/jump: imm16=16'hFFFF, d_pc=0x3008 -> pc=0x3008; j_en=1, instr_index=26'h0000C10, d_pc=0x3000 -> pc=0x0000_3040; pc_plus8=0x3008.
- Priority/stall: jr_en=1, j_en=1, jr_target=0x4000 -> pc=0x4000; same inputs with stall=1 -> redirect=0, pc unchanged.
- Pending: taken branch to 0x3010 with fetch_ready=0 for 3 cycles -> pending=1, pc holds 0x3004; on the first fetch_ready=1 edge pc=0x3010, pending=0. Repeat with reset pulsed mid-hold -> pc=0x3000, pending=0.
- With IFU_BRANCH_STATS_EN: 5 branches with judge=1,0,1,1,0, one of them stalled for 2 cycles -> br_count=5, br_taken_count=3.
